fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Read-domain adapter placed directly downstream of the asynchronous FIFO. It converts the FIFO's read-request interface (rd_en / rd_empty, data one cycle after the accepted request) into a valid/ready stream. It holds a 3-entry output buffer so it sustains one word per cycle with no combinational path from m_ready to the FIFO read enable. It also frames the stream into fixed-length packets by tagging every PKT_LEN-th word with m_last.

## Interface
- BITS, 32, word width; must match the FIFO's BITS.
- PKT_LEN, 4, words per packet; legal range 1..65535; 1 means every word is last.
- rd_clk  input  1  read-domain clock; same clock as the FIFO read side.
- rd_rst_n  input  1  reset; asynchronous assert, active-low.
- fifo_rd_en  output  1  read request to the FIFO.
- fifo_rd_data  input  BITS  FIFO read data; valid in the cycle after an accepted fifo_rd_en.
- fifo_rd_empty  input  1  FIFO empty flag.
- m_valid  output  1  output word available.
- m_ready  input  1  consumer accepts the word.
- m_data  output  BITS  output word.
- m_last  output  1  word is the last of a packet.
- level  output  2  buffered words plus in-flight read, 0..3.

## Operation
- State registers:
  - occ: number of buffered words, 0..3.
  - pend: 1 if fifo_rd_en was asserted in the previous cycle.
  - A 3-entry circular buffer of {last, data}, with head and tail pointers modulo 3.
  - beat_cnt: width clog2(PKT_LEN)+1.
- fifo_rd_en = rd_rst_n && !fifo_rd_empty && (occ + pend < 3). It depends only on registered state and fifo_rd_empty, never on m_ready.
- pend <= fifo_rd_en every cycle.
- Capture: when pend = 1, write fifo_rd_data into the buffer at tail and advance tail.
  - The stored last bit is (beat_cnt == PKT_LEN-1).
  - beat_cnt then wraps to 0 if last, otherwise increments.
- Pop: when m_valid && m_ready, advance head.
- occ <= occ + capture - pop. A capture and a pop in the same cycle leave occ unchanged.
- m_valid = (occ != 0). m_data and m_last are read from the buffer at head.
- level = occ + pend.
- Packet framing counts captured words, not popped words. Order is preserved, so the tags are consistent at the output.
- The block never drops or duplicates a word. Words leave in FIFO order.

## Timing
- Reset values while rd_rst_n = 0:
  - fifo_rd_en = 0, m_valid = 0, m_data = 0, m_last = 0, level = 0.
  - occ, pend, head, tail and beat_cnt are all 0.
- Reset mid-operation discards all buffered and in-flight words and restarts framing at beat 0. The FIFO is reset together with this block, so no orphan data remains.
- Latency: fifo_rd_en high in cycle t → fifo_rd_data valid in t+1 → m_valid high in t+2.
- Throughput: with m_ready held high and the FIFO non-empty, the steady state is occ=1, pend=1. fifo_rd_en stays high and one word is transferred per cycle.
- Backpressure with m_ready = 0:
  - Reads stop once occ + pend = 3.
  - The in-flight word always has a free slot, so no overflow is possible.
- Handshake rules:
  - m_data and m_last stay stable while m_valid && !m_ready.
  - m_valid never deasserts without a pop.
- FIFO empty: fifo_rd_en stays low. Buffered words continue to drain.
- Simultaneous capture, pop and new fifo_rd_en in one cycle is legal and required at full throughput.
- Buffer pointer wrap: index 2 advances to 0.
- beat_cnt wrap: PKT_LEN-1 advances to 0.

## Test plan
- Reset, FIFO empty, m_ready=1:
  - All outputs 0; fifo_rd_en never rises.
- Single word:
  - Stimulus: FIFO supplies 0xA5A5_0001 with empty low for one request.
  - Required: fifo_rd_en for one cycle; m_valid two cycles later with m_data=0xA5A5_0001; m_last=0 (PKT_LEN=4).
- Streaming:
  - Stimulus: 12 words 0..11, m_ready=1.
  - Required: after the initial 2-cycle latency, one word per cycle; m_last high on words 3, 7 and 11.
- Backpressure:
  - Stimulus: 8 words queued, m_ready=0 for 10 cycles, then m_ready=1.
  - Required: fifo_rd_en asserts exactly 3 times and level=3 while stalled. After release, words 0..7 come out in order, with none lost or duplicated, and m_data stable during the stall.
- Random m_ready and random fifo_rd_empty over 1000 words:
  - Scoreboard order is exact; level never exceeds 3; m_last appears every 4th word.
- Reset mid-stream:
  - Stimulus: assert rd_rst_n=0 with occ=2 and pend=1, then release.
  - Required: outputs drop to 0 asynchronously; the first post-reset packet's 4th word carries m_last.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns the asynchronous FIFO's read-request interface into a
// valid/ready stream. A 3-entry buffer absorbs the one-cycle read latency, so
// the block sustains one word per cycle. fifo_rd_en is a function of
// registered state and fifo_rd_empty only, with no combinational path from
// m_ready. Every PKT_LEN-th captured word is tagged with m_last.
module fifo_rd_stream #(
  parameter int BITS    = 32,
  parameter int PKT_LEN = 4
) (
  input  logic            rd_clk,
  input  logic            rd_rst_n,
  output logic            fifo_rd_en,
  input  logic [BITS-1:0] fifo_rd_data,
  input  logic            fifo_rd_empty,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [BITS-1:0] m_data,
  output logic            m_last,
  output logic [1:0]      level
);

  localparam int CW = $clog2(PKT_LEN) + 1;

  typedef struct packed {
    logic            last;
    logic [BITS-1:0] data;
  } entry_t;

  entry_t          mem_q [3];
  logic [1:0]      occ_q, occ_d;
  logic            pend_q;
  logic [1:0]      head_q, head_d;
  logic [1:0]      tail_q, tail_d;
  logic [CW-1:0]   beat_q, beat_d;

  logic [2:0]      inflight;
  logic            capture;
  logic            pop;
  logic            last_in;

  // Read request, occupancy view and the handshake seen by the consumer.
  always_comb begin
    inflight   = {1'b0, occ_q} + {2'b00, pend_q};
    // The in-flight word is counted, so a read is only issued when its
    // landing slot is guaranteed free regardless of m_ready.
    fifo_rd_en = rd_rst_n && !fifo_rd_empty && (inflight < 3'd3);
    level      = inflight[1:0];
    m_valid    = (occ_q != 2'd0);
    m_data     = mem_q[head_q].data;
    m_last     = mem_q[head_q].last;
    capture    = pend_q;
    pop        = m_valid && m_ready;
    last_in    = (beat_q == CW'(PKT_LEN - 1));
  end

  // Next-state for occupancy, pointers and packet beat counter.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    beat_d = beat_q;
    if (capture) begin
      tail_d = (tail_q == 2'd2) ? 2'd0 : tail_q + 2'd1;
      beat_d = last_in ? '0 : beat_q + CW'(1);
    end
    if (pop) begin
      head_d = (head_q == 2'd2) ? 2'd0 : head_q + 2'd1;
    end
    case ({capture, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // State registers and buffer write on capture.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      // NOTE: non-blocking assignments for all sequential state so every
      // register samples pre-edge values regardless of statement order.
      occ_q  <= '0;
      pend_q <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
      beat_q <= '0;
      // NOTE: the buffer is reset because m_data/m_last read it directly and
      // must be 0 during reset; with three entries this is cheap.
      for (int i = 0; i < 3; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      occ_q  <= occ_d;
      pend_q <= fifo_rd_en;
      head_q <= head_d;
      tail_q <= tail_d;
      beat_q <= beat_d;
      if (capture) begin
        mem_q[tail_q] <= '{last: last_in, data: fifo_rd_data};
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream (BITS=32, PKT_LEN=4). A queue models the
// upstream FIFO (data appears the cycle after an accepted read) and a second
// queue holds the words expected at the output, in order.
module tb_fifo_rd_stream;

  logic        rd_clk = 1'b0;
  logic        rd_rst_n;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data;
  logic        fifo_rd_empty;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic [1:0]  level;

  fifo_rd_stream #(.BITS(32), .PKT_LEN(4)) dut (
    .rd_clk       (rd_clk),
    .rd_rst_n     (rd_rst_n),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .level        (level)
  );

  always #5 rd_clk = ~rd_clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] src [$];
  logic [31:0] exp_q [$];
  int          p_idx = 0;
  int          rd_en_cnt = 0;
  int          empty_viol = 0;
  int          stab_viol = 0;
  int          extra_words = 0;
  bit          rand_empty = 0;
  bit          rand_ready = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data;
  logic        prev_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: sample outputs mid-cycle, then update the FIFO model after the edge.
  task automatic tick();
    bit          acc;
    logic [31:0] w;
    @(negedge rd_clk);
    acc = fifo_rd_en && !fifo_rd_empty;
    if (fifo_rd_en) rd_en_cnt++;
    if (fifo_rd_en && fifo_rd_empty) empty_viol++;
    if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stab_viol++;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        extra_words++;
      end else begin
        w = exp_q.pop_front();
        check("word_data", m_data, w);
        check("word_last", {31'b0, m_last}, {31'b0, (p_idx % 4) == 3});
        p_idx++;
      end
    end
    @(posedge rd_clk);
    #1;
    if (acc) fifo_rd_data = src.pop_front();
    fifo_rd_empty = (src.size() == 0) || (rand_empty && ($urandom_range(0, 1) == 1));
    if (rand_ready) m_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic load(input int n, input logic [31:0] base, input bit rnd);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = rnd ? $urandom() : base + i;
      src.push_back(w);
      exp_q.push_back(w);
    end
    fifo_rd_empty = 1'b0;
  endtask

  task automatic do_reset();
    rd_rst_n      = 1'b0;
    fifo_rd_empty = 1'b1;
    src.delete();
    exp_q.delete();
    p_idx      = 0;
    prev_stall = 0;
    repeat (2) @(posedge rd_clk);
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
    @(posedge rd_clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_rst_n      = 1'b0;
    fifo_rd_empty = 1'b1;
    fifo_rd_data  = '0;
    m_ready       = 1'b1;
    #3;
    check("rst_rd_en",   {31'b0, fifo_rd_en}, 0);
    check("rst_m_valid", {31'b0, m_valid}, 0);
    check("rst_m_data",  m_data, 0);
    check("rst_m_last",  {31'b0, m_last}, 0);
    check("rst_level",   {30'b0, level}, 0);

    // Idle with FIFO empty: no reads.
    do_reset();
    rd_en_cnt = 0;
    repeat (5) tick();
    check("idle_rd_en_cnt", rd_en_cnt, 0);
    check("idle_m_valid", {31'b0, m_valid}, 0);

    // Single word: request, one-cycle data, output two cycles after request.
    rd_en_cnt = 0;
    load(1, 32'hA5A5_0001, 0);
    #1;
    check("single_rd_en_t0", {31'b0, fifo_rd_en}, 1);
    check("single_valid_t0", {31'b0, m_valid}, 0);
    tick(); #1;
    check("single_rd_en_t1", {31'b0, fifo_rd_en}, 0);
    check("single_valid_t1", {31'b0, m_valid}, 0);
    check("single_level_t1", {30'b0, level}, 1);
    tick(); #1;
    check("single_valid_t2", {31'b0, m_valid}, 1);
    check("single_data_t2",  m_data, 32'hA5A5_0001);
    check("single_last_t2",  {31'b0, m_last}, 0);
    tick(); #1;
    check("single_valid_t3", {31'b0, m_valid}, 0);
    check("single_rd_en_cnt", rd_en_cnt, 1);

    // Streaming 12 words at full rate: pops in cycles 2..13.
    do_reset();
    load(12, 32'h0, 0);
    repeat (13) tick();
    check("stream_left_after13", exp_q.size(), 1);
    tick();
    check("stream_left_after14", exp_q.size(), 0);

    // Backpressure: 8 words queued, consumer stalled for 10 cycles.
    do_reset();
    m_ready   = 1'b0;
    rd_en_cnt = 0;
    load(8, 32'hB000_0000, 0);
    repeat (10) tick();
    #1;
    check("bp_rd_en_cnt", rd_en_cnt, 3);
    check("bp_level", {30'b0, level}, 3);
    check("bp_head_data", m_data, 32'hB000_0000);
    check("bp_valid", {31'b0, m_valid}, 1);
    m_ready = 1'b1;
    drain(40);

    // Random ready and empty over 1000 words.
    do_reset();
    rand_empty = 1;
    rand_ready = 1;
    load(1000, 32'h0, 1);
    drain(20000);
    rand_empty = 0;
    rand_ready = 0;
    m_ready    = 1'b1;

    // Reset mid-stream with occ=2, pend=1.
    do_reset();
    m_ready = 1'b0;
    load(8, 32'hC000_0000, 0);
    repeat (3) tick();
    #1;
    check("mid_level_before", {30'b0, level}, 3);
    rd_rst_n = 1'b0;
    #1;
    check("mid_rst_rd_en",   {31'b0, fifo_rd_en}, 0);
    check("mid_rst_m_valid", {31'b0, m_valid}, 0);
    check("mid_rst_m_data",  m_data, 0);
    check("mid_rst_level",   {30'b0, level}, 0);
    do_reset();
    m_ready = 1'b1;
    load(4, 32'hD000_0000, 0);
    drain(20);

    check("rd_en_while_empty", empty_viol, 0);
    check("stall_stability", stab_viol, 0);
    check("extra_words", extra_words, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
